// File: rtl/rate1_node_ctrl.sv
// Rate-1 node sequencer for the polar SC decoder: streams 16-LLR chunks from LLR
// memory through the hard-decision datapath and writes each decision word to bit memory.
module rate1_node_ctrl #(
    parameter int LLR_W   = 6,
    parameter int PU_NUM  = 16,
    parameter int ADDR_W  = 8,
    parameter int MAX_LOG = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                node_log,
    input  logic [ADDR_W-1:0]         llr_base,
    input  logic [ADDR_W-1:0]         bit_base,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_gnt,
    input  logic [PU_NUM*LLR_W-1:0]   rd_data,
    output logic [PU_NUM*LLR_W-1:0]   pu_llr,
    input  logic [PU_NUM-1:0]         pu_bits,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [PU_NUM-1:0]         wr_data
);

    // Chunk indices run 0..2^(MAX_LOG-4)-1; one spare bit keeps the count itself representable.
    localparam int CW = MAX_LOG - 3;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   llr_base_q, bit_base_q;
    logic [CW-1:0]       last_idx_q, last_idx_d;
    logic [CW-1:0]       rd_idx_q, wr_idx_q;
    logic                v1_q, v2_q;
    logic                err_q;
    logic [PU_NUM-1:0]   wr_data_q;

    logic legal, accept, rd_issue, last_rd, last_wr;

    assign legal      = (node_log >= 4'd4) && (node_log <= 4'(MAX_LOG));
    assign accept     = (state_q == IDLE) && start && legal;
    assign rd_issue   = rd_en && rd_gnt;
    assign last_rd    = (rd_idx_q == last_idx_q);
    assign last_wr    = (wr_idx_q == last_idx_q);
    assign last_idx_d = (ONE << (node_log - 4'd4)) - ONE;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned and infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (rd_issue && last_rd) state_d = DRAIN;
            DRAIN:   if (v2_q && last_wr) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        rd_en = (state_q == RUN);
    end

    // Captured node parameters, chunk counters and the two-stage read-to-write pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            llr_base_q <= '0;
            bit_base_q <= '0;
            last_idx_q <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            err_q      <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            if (accept) begin
                llr_base_q <= llr_base;
                bit_base_q <= bit_base;
                last_idx_q <= last_idx_d;
                rd_idx_q   <= '0;
                wr_idx_q   <= '0;
            end else begin
                if (rd_issue) rd_idx_q <= rd_idx_q + ONE;
                if (v2_q)     wr_idx_q <= wr_idx_q + ONE;
            end
            // rd_data (and hence pu_bits) is valid the cycle after the read issues.
            v1_q  <= rd_issue;
            v2_q  <= v1_q;
            if (v1_q) wr_data_q <= pu_bits;
            err_q <= (state_q == IDLE) && start && !legal;
        end
    end

    assign rd_addr = llr_base_q + ADDR_W'(rd_idx_q);
    assign wr_addr = bit_base_q + ADDR_W'(wr_idx_q);
    assign wr_en   = v2_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign pu_llr  = rd_data;

endmodule

// File: tb/tb_rate1_node_ctrl.sv
// Self-checking bench for rate1_node_ctrl: table of node runs plus hand-written
// reset, start-while-busy and back-to-back sequences, with a write scoreboard.
module tb_rate1_node_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  node_log;
    logic [7:0]  llr_base, bit_base;
    logic        busy, done, err, rd_en, rd_gnt, wr_en;
    logic [7:0]  rd_addr, wr_addr;
    logic [95:0] rd_data, pu_llr;
    logic [15:0] pu_bits, wr_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]  node_log;
        logic [7:0]  llr_base;
        logic [7:0]  bit_base;
        logic [31:0] gnt_mask;   // bit r = grant in the r-th cycle with rd_en high
        bit          all_neg;
        bit          exp_err;
        int          exp_done;   // cycle of done, counted from the start cycle
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          k;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb_q [$];

    rate1_node_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .node_log (node_log),
        .llr_base (llr_base),
        .bit_base (bit_base),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_gnt   (rd_gnt),
        .rd_data  (rd_data),
        .pu_llr   (pu_llr),
        .pu_bits  (pu_bits),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: hard decision (sign bit) per lane, bit-reversed lane order.
    function automatic logic [15:0] hd_rev(input logic [95:0] w);
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[i] = w[(15 - i) * 6 + 5];
        return b;
    endfunction

    always_comb pu_bits = hd_rev(pu_llr);

    // LLR memory contents, a fixed function of the address.
    function automatic logic [95:0] mem_word(input logic [7:0] a, input bit neg);
        logic [95:0] w;
        logic [5:0]  l;
        for (int j = 0; j < 16; j++) begin
            l = 6'((int'(a) * 5 + j * 19 + int'(a) * j * 3 + 7) % 64);
            if (neg) l[5] = 1'b1;
            w[j * 6 +: 6] = l;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_node(input vec_t v, input bit start_in_done, input int poke_k);
        int          k, r, reads, writes, chunks, last_k;
        int          done_k, done_cnt, err_k, err_cnt, busy_cnt, first_rd_k;
        logic        issued_prev;
        logic [7:0]  addr_prev, exp_a;
        sb_t         e;
        chunks = v.exp_err ? 0 : (1 << (v.node_log - 4));
        last_k = v.exp_err ? 6 : 60;
        r = 0; reads = 0; writes = 0;
        done_k = -1; done_cnt = 0; err_k = -1; err_cnt = 0; busy_cnt = 0; first_rd_k = -1;
        issued_prev = 1'b0;
        addr_prev   = '0;
        start    = 1'b1;
        node_log = v.node_log;
        llr_base = v.llr_base;
        bit_base = v.bit_base;
        rd_gnt   = v.gnt_mask[0];
        for (k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            if (done_k >= 0) begin
                check("idle_after_done", {30'd0, busy, rd_en}, 32'd0);
                start = 1'b0;
                break;
            end
            start = 1'b0;
            if (k == poke_k) begin
                start    = 1'b1;
                node_log = 4'd4;
                llr_base = 8'hAA;
                bit_base = 8'h55;
            end
            rd_data = issued_prev ? mem_word(addr_prev, v.all_neg) : {$urandom, $urandom, $urandom};
            rd_gnt  = (r < 32) ? v.gnt_mask[r] : 1'b1;
            issued_prev = 1'b0;
            if (rd_en) begin
                if (first_rd_k < 0) first_rd_k = k;
                exp_a = v.llr_base + 8'(reads);
                check("rd_addr", rd_addr, exp_a);
                if (rd_gnt) begin
                    e.addr = v.bit_base + 8'(reads);
                    e.data = hd_rev(mem_word(exp_a, v.all_neg));
                    e.k    = k;
                    sb_q.push_back(e);
                    issued_prev = 1'b1;
                    addr_prev   = exp_a;
                    reads++;
                end
                r++;
            end
            if (wr_en) begin
                writes++;
                if (sb_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("wr_latency", k, e.k + 2);
                end
            end
            if (busy) busy_cnt++;
            if (err) begin err_cnt++; err_k = k; end
            if (done) begin
                done_cnt++;
                done_k = k;
                if (start_in_done) begin
                    start    = 1'b1;
                    node_log = 4'd5;
                    llr_base = 8'hCC;
                    bit_base = 8'hDD;
                end
            end
        end
        check("reads", reads, chunks);
        check("writes", writes, chunks);
        check("sb_empty", sb_q.size(), 0);
        sb_q.delete();
        check("first_rd", first_rd_k, v.exp_err ? -1 : 1);
        check("done_cycle", done_k, v.exp_err ? -1 : v.exp_done);
        check("done_cnt", done_cnt, v.exp_err ? 0 : 1);
        check("busy_cycles", busy_cnt, v.exp_err ? 0 : v.exp_done);
        check("err_cycle", err_k, v.exp_err ? 1 : -1);
        check("err_cnt", err_cnt, v.exp_err ? 1 : 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        node_log = '0;
        llr_base = '0;
        bit_base = '0;
        rd_gnt   = 1'b0;
        rd_data  = '0;

        //           node_log llr    bit    gnt_mask       neg  err  done
        vecs[0] = '{4'd4, 8'h10, 8'h40, 32'hFFFF_FFFF, 1'b1, 1'b0, 4};
        vecs[1] = '{4'd6, 8'h20, 8'h80, 32'hFFFF_FFFF, 1'b0, 1'b0, 7};
        vecs[2] = '{4'd5, 8'h30, 8'h90, 32'hFFFF_FFF9, 1'b0, 1'b0, 7};
        vecs[3] = '{4'd3, 8'h10, 8'h40, 32'hFFFF_FFFF, 1'b0, 1'b1, 0};
        vecs[4] = '{4'd9, 8'h10, 8'h40, 32'hFFFF_FFFF, 1'b0, 1'b1, 0};
        vecs[5] = '{4'd6, 8'hFE, 8'hFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 7};
        vecs[6] = '{4'd8, 8'h05, 8'h33, 32'hFFFF_FDEF, 1'b0, 1'b0, 21};
        vecs[7] = '{4'd7, 8'h00, 8'hF8, 32'hFFFF_FFFF, 1'b0, 1'b0, 11};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_node(vecs[i], 1'b0, 0);

        // Start pulsed mid-node with other parameters must be ignored.
        run_node(vecs[1], 1'b0, 2);
        // Start in the done cycle is ignored; the next cycle's start is accepted.
        run_node(vecs[2], 1'b1, 0);
        run_node(vecs[0], 1'b0, 0);

        // Reset during the second read of a node_log=7 run.
        start    = 1'b1;
        node_log = 4'd7;
        llr_base = 8'h60;
        bit_base = 8'h70;
        rd_gnt   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_rd0", {23'd0, rd_en, rd_addr}, {23'd0, 1'b1, 8'h60});
        @(posedge clk); #1;
        check("abort_rd1", {23'd0, rd_en, rd_addr}, {23'd0, 1'b1, 8'h61});
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_done_err", {30'd0, done, err}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_quiet", {29'd0, wr_en, busy, rd_en}, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", busy, 0);

        run_node(vecs[7], 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
